// File: rtl/sparse_act_encoder.sv
// Sparse activation encoder: packs the nonzero pixels of a raster-ordered dense map into
// 4-lane groups with per-lane coordinates, behind a valid/ready output register.
module sparse_act_encoder #(
  parameter int wordlength = 16,
  parameter int col_length = 5,
  parameter int ch_width   = 6
) (
  input  logic                         clk,
  input  logic                         irst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [wordlength-1:0] pixel_in,
  input  logic [ch_width-1:0]          in_channel,
  input  logic [col_length-1:0]        cfg_cols,
  input  logic [col_length-1:0]        cfg_rows,
  output logic [4*wordlength-1:0]      data_out,
  output logic [4*col_length-1:0]      data_out_cols,
  output logic [4*col_length-1:0]      data_out_rows,
  output logic [3:0]                   out_lane_mask,
  output logic [ch_width-1:0]          out_channel,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic                    live;
  logic [ch_width-1:0]     ch_q;
  logic [col_length-1:0]   cols_q, rows_q, col_q, row_q;
  logic [1:0]              cnt;
  logic [4*wordlength-1:0] buf_data;
  logic [4*col_length-1:0] buf_cols, buf_rows;
  logic [3:0]              buf_mask;

  logic                    accept, idle, nz, chan_end, row_wrap, emit;
  logic [col_length-1:0]   eff_cols, eff_rows, cur_col, cur_row;
  logic [ch_width-1:0]     cur_ch;
  logic [4*wordlength-1:0] ins_data;
  logic [4*col_length-1:0] ins_cols, ins_rows;
  logic [3:0]              ins_mask;

  // live keeps in_ready low while in reset, even though out_valid is already 0
  assign in_ready = live & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign idle     = (state_q == IDLE);
  assign nz       = (pixel_in != '0);

  // The first pixel of a channel is processed against the live cfg inputs, not the latches
  assign eff_cols = idle ? ((cfg_cols == '0) ? col_length'(1) : cfg_cols) : cols_q;
  assign eff_rows = idle ? ((cfg_rows == '0) ? col_length'(1) : cfg_rows) : rows_q;
  assign cur_col  = idle ? '0 : col_q;
  assign cur_row  = idle ? '0 : row_q;
  assign cur_ch   = idle ? in_channel : ch_q;

  assign row_wrap = (cur_col == eff_cols - col_length'(1));
  assign chan_end = row_wrap && (cur_row == eff_rows - col_length'(1));
  assign emit     = accept && ((nz && cnt == 2'd3) || chan_end);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ins_data = buf_data;
    ins_cols = buf_cols;
    ins_rows = buf_rows;
    ins_mask = buf_mask;
    if (nz) begin
      ins_data[int'(cnt)*wordlength +: wordlength] = pixel_in;
      ins_cols[int'(cnt)*col_length +: col_length] = cur_col;
      ins_rows[int'(cnt)*col_length +: col_length] = cur_row;
      ins_mask[cnt]                                = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = chan_end ? IDLE : RUN;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= IDLE;
      live    <= 1'b0;
    end else begin
      state_q <= state_d;
      live    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      ch_q     <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      cnt      <= '0;
      buf_data <= '0;
      buf_cols <= '0;
      buf_rows <= '0;
      buf_mask <= '0;
    end else if (accept) begin
      if (idle) begin
        ch_q   <= in_channel;
        cols_q <= eff_cols;
        rows_q <= eff_rows;
      end
      col_q <= row_wrap ? '0 : cur_col + col_length'(1);
      row_q <= row_wrap ? cur_row + col_length'(1) : cur_row;
      if (emit) begin
        cnt      <= '0;
        buf_data <= '0;
        buf_cols <= '0;
        buf_rows <= '0;
        buf_mask <= '0;
      end else begin
        cnt      <= cnt + {1'b0, nz};
        buf_data <= ins_data;
        buf_cols <= ins_cols;
        buf_rows <= ins_rows;
        buf_mask <= ins_mask;
      end
    end
  end

  // Output register: loads on emit, otherwise holds until the downstream takes it
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      data_out      <= '0;
      data_out_cols <= '0;
      data_out_rows <= '0;
      out_lane_mask <= '0;
      out_channel   <= '0;
      out_last      <= 1'b0;
      out_valid     <= 1'b0;
    end else if (emit) begin
      data_out      <= ins_data;
      data_out_cols <= ins_cols;
      data_out_rows <= ins_rows;
      out_lane_mask <= ins_mask;
      out_channel   <= cur_ch;
      out_last      <= chan_end;
      out_valid     <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sparse_act_encoder.sv
// Scoreboard bench for sparse_act_encoder: directed maps push expected groups, and a
// negedge monitor pops and compares each group the DUT hands over.
module tb_sparse_act_encoder;
  localparam int W  = 16;
  localparam int C  = 5;
  localparam int CH = 6;

  logic                clk = 1'b0;
  logic                irst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] pixel_in;
  logic [CH-1:0]       in_channel;
  logic [C-1:0]        cfg_cols, cfg_rows;
  logic [4*W-1:0]      data_out;
  logic [4*C-1:0]      data_out_cols, data_out_rows;
  logic [3:0]          out_lane_mask;
  logic [CH-1:0]       out_channel;
  logic                out_last, out_valid, out_ready;

  sparse_act_encoder #(.wordlength(W), .col_length(C), .ch_width(CH)) dut (
    .clk(clk), .irst_n(irst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in(pixel_in), .in_channel(in_channel), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .data_out(data_out), .data_out_cols(data_out_cols), .data_out_rows(data_out_rows),
    .out_lane_mask(out_lane_mask), .out_channel(out_channel), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*W-1:0] data;
    logic [4*C-1:0] cols;
    logic [4*C-1:0] rows;
    logic [3:0]     mask;
    logic [CH-1:0]  ch;
    logic           last;
  } grp_t;

  grp_t sb[$];
  int   pix_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic grp_t mk(input int n,
                              input int d0, input int d1, input int d2, input int d3,
                              input int c0, input int c1, input int c2, input int c3,
                              input int r0, input int r1, input int r2, input int r3,
                              input int ch, input bit last);
    grp_t g;
    g.data = {W'(d3), W'(d2), W'(d1), W'(d0)};
    g.cols = {C'(c3), C'(c2), C'(c1), C'(c0)};
    g.rows = {C'(r3), C'(r2), C'(r1), C'(r0)};
    g.mask = 4'((1 << n) - 1);
    g.ch   = CH'(ch);
    g.last = last;
    return g;
  endfunction

  // Monitor: one comparison set per handed-over group
  always @(negedge clk) begin
    if (irst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_group: got mask %b last %b expected no group", out_lane_mask, out_last);
      end else begin
        grp_t e;
        e = sb.pop_front();
        check("grp_data", 64'(data_out), 64'(e.data));
        check("grp_cols", 64'(data_out_cols), 64'(e.cols));
        check("grp_rows", 64'(data_out_rows), 64'(e.rows));
        check("grp_mask", 64'(out_lane_mask), 64'(e.mask));
        check("grp_channel", 64'(out_channel), 64'(e.ch));
        check("grp_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  task automatic send_px(input int v);
    int n;
    n = 0;
    in_valid = 1'b1;
    pixel_in = W'(v);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_map(input int cols, input int rows, input int ch);
    cfg_cols   = C'(cols);
    cfg_rows   = C'(rows);
    in_channel = CH'(ch);
    foreach (pix_q[i]) begin
      send_px(pix_q[i]);
      // Changes during RUN must be ignored by the encoder
      cfg_cols   = C'(cols + 3);
      cfg_rows   = C'(rows + 1);
      in_channel = CH'(ch + 9);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic push_5x3(input int ch);
    sb.push_back(mk(4, 1, 2, 3, 4, 0, 1, 2, 3, 0, 0, 0, 0, ch, 0));
    sb.push_back(mk(4, 5, 6, 7, 8, 4, 0, 1, 2, 0, 1, 1, 1, ch, 0));
    sb.push_back(mk(4, 9, 10, 11, 12, 3, 4, 0, 1, 1, 1, 2, 2, ch, 0));
    sb.push_back(mk(3, 13, 14, 15, 0, 2, 3, 4, 0, 2, 2, 2, 0, ch, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    irst_n     = 1'b0;
    in_valid   = 1'b0;
    pixel_in   = '0;
    in_channel = '0;
    cfg_cols   = '0;
    cfg_rows   = '0;
    out_ready  = 1'b1;
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_mask_last", 64'({out_lane_mask, out_last}), 64'd0);
    @(posedge clk);
    #1;
    irst_n = 1'b1;

    // 5x3 dense map, four groups
    push_5x3(5);
    pix_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    run_map(5, 3, 5);
    drain("drain_5x3");

    // Sparse 4x2 map including a negative value
    sb.push_back(mk(2, 7, -3, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 3, 1));
    pix_q = '{0, 7, 0, 0, 0, 0, -3, 0};
    run_map(4, 2, 3);
    drain("drain_4x2");

    // All-zero channel still emits one empty last group
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    pix_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_map(3, 3, 2);
    drain("drain_zero");

    // Channel end coincides with a full group: no extra empty group
    sb.push_back(mk(4, 1, 2, 3, 4, 0, 1, 0, 1, 0, 0, 1, 1, 7, 1));
    pix_q = '{1, 2, 3, 4};
    run_map(2, 2, 7);
    drain("drain_2x2");

    // Backpressure: group0 held for 6 cycles with in_ready low
    push_5x3(4);
    pix_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    out_ready = 1'b0;
    fork
      run_map(5, 3, 4);
      begin
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("stall_seen", 64'(out_valid), 64'd1);
        repeat (6) begin
          @(negedge clk);
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", 64'(data_out), 64'h0004_0003_0002_0001);
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Abort mid-channel with reset; the partial group must not survive
    sb.push_back(mk(4, 1, 2, 3, 4, 0, 1, 2, 3, 0, 0, 0, 0, 6, 0));
    pix_q = '{1, 2, 3, 4, 5, 6};
    run_map(5, 3, 6);
    drain("drain_partial");
    irst_n = 1'b0;
    #2;
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    irst_n = 1'b1;
    sb.push_back(mk(2, 9, 8, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1));
    pix_q = '{9, 0, 0, 8};
    run_map(2, 2, 1);
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
